apb_req_arbiter: RTL and testbench

APB master-side arbiter that shares the single UART APB register slave (baud divisor, status and data registers) between two requesters: the host command port (requester 0) and the receive-drain engine (requester 1). It accepts one transfer request per requester, selects a winner round-robin, and drives a complete APB SETUP/ACCESS sequence to the slave. It waits for `pready`, returns read data, and signals completion or timeout to the winning requester. It sits between the requesters and the UART register slave's `psel/penable/pwrite/P_ADDR/PW_DATA/Pr_data/P_READY` pins.

---
 rtl/apb_req_arbiter_if.sv | 42 ++++
 rtl/apb_req_arbiter.sv | 136 +++++++++++++
 tb/tb_apb_req_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_req_arbiter_if.sv
// Requester-side and APB-side signals of the two-port APB request arbiter.
// The master modport is the arbiter's view. The slave modport is the view of the requesters and the register slave.
interface apb_req_arbiter_if #(
    parameter int BITWIDTH = 8,
    parameter int ADDRW    = 2
);
    logic                req0;
    logic                req1;
    logic                wr0;
    logic                wr1;
    logic [ADDRW-1:0]    addr0;
    logic [ADDRW-1:0]    addr1;
    logic [BITWIDTH-1:0] wdata0;
    logic [BITWIDTH-1:0] wdata1;
    logic                done0;
    logic                done1;
    logic                err;
    logic [BITWIDTH-1:0] rdata;
    logic                busy;

    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [ADDRW-1:0]    paddr;
    logic [BITWIDTH-1:0] pwdata;
    logic [BITWIDTH-1:0] prdata;
    logic                pready;

    modport master (
        input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
        input  prdata, pready,
        output done0, done1, err, rdata, busy,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
        output prdata, pready,
        input  done0, done1, err, rdata, busy,
        input  psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// Shares one APB register slave between two requesters, round-robin on contention, with an ACCESS timeout.
// SETUP follows the sampled request by one cycle, then DONE follows ACCESS. Requests held while busy are re-arbitrated in the next IDLE.
module apb_req_arbiter #(
    parameter int BITWIDTH = 8,
    parameter int ADDRW    = 2,
    parameter int TIMEOUT  = 16
) (
    input  logic              pclk,
    input  logic              preset,
    apb_req_arbiter_if.master bus
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_last;
    logic [CW-1:0]       r_cnt;
    logic                r_psel;
    logic                r_penable;
    logic                r_pwrite;
    logic [ADDRW-1:0]    r_paddr;
    logic [BITWIDTH-1:0] r_pwdata;
    logic [BITWIDTH-1:0] r_rdata;
    logic                r_done0;
    logic                r_done1;
    logic                r_err;
    logic                r_busy;

    logic                w_any_req;
    logic                w_pick1;
    logic                w_wr;
    logic [ADDRW-1:0]    w_addr;
    logic [BITWIDTH-1:0] w_wdata;

    // On contention, requester 1 wins only if requester 0 was granted last.
    assign w_any_req = bus.req0 | bus.req1;
    assign w_pick1   = bus.req1 & (~bus.req0 | ~r_last);
    assign w_wr      = w_pick1 ? bus.wr1    : bus.wr0;
    assign w_addr    = w_pick1 ? bus.addr1  : bus.addr0;
    assign w_wdata   = w_pick1 ? bus.wdata1 : bus.wdata0;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_cnt     <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_rdata   <= '0;
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state   <= SETUP;
                        r_busy    <= 1'b1;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_pwrite  <= w_wr;
                        r_paddr   <= w_addr;
                        r_pwdata  <= w_wdata;
                        r_last    <= w_pick1;
                    end
                end
                SETUP: begin
                    r_state   <= ACCESS;
                    r_penable <= 1'b1;
                    r_cnt     <= '0;
                end
                ACCESS: begin
                    if (bus.pready) begin
                        r_state   <= DONE;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_done0   <= ~r_last;
                        r_done1   <= r_last;
                        if (!r_pwrite) begin
                            r_rdata <= bus.prdata;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        // Timed out: complete with error, read data left untouched.
                        r_state   <= DONE;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_done0   <= ~r_last;
                        r_done1   <= r_last;
                        r_err     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_busy    <= 1'b0;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    assign bus.psel    = r_psel;
    assign bus.penable = r_penable;
    assign bus.pwrite  = r_pwrite;
    assign bus.paddr   = r_paddr;
    assign bus.pwdata  = r_pwdata;
    assign bus.rdata   = r_rdata;
    assign bus.done0   = r_done0;
    assign bus.done1   = r_done1;
    assign bus.err     = r_err;
    assign bus.busy    = r_busy;

    a_done_excl: assert property (@(posedge pclk) disable iff (preset) !(r_done0 && r_done1));
    a_err_with_done: assert property (@(posedge pclk) disable iff (preset) r_err |-> (r_done0 || r_done1));
    a_penable_with_psel: assert property (@(posedge pclk) disable iff (preset) r_penable |-> r_psel);
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter: a slave model with programmable wait states and expected transfers queued at stimulus time.
module tb_apb_req_arbiter;
    localparam int BW = 8;
    localparam int AW = 2;
    localparam int TO = 16;

    logic pclk;
    logic preset;

    apb_req_arbiter_if #(.BITWIDTH(BW), .ADDRW(AW)) bus ();

    apb_req_arbiter #(.BITWIDTH(BW), .ADDRW(AW), .TIMEOUT(TO)) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus)
    );

    typedef struct {
        int          id;
        logic        wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
        logic [BW-1:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            slv_wait;
    int            slv_n;
    logic [BW-1:0] slv_rdata;
    logic [BW-1:0] exp_rdata;
    int            m_last;
    int            mon_acc;
    bit            mon_setup;
    int            cyc;
    int            first;

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push(input int id, input logic wr, input logic [AW-1:0] addr,
                                 input logic [BW-1:0] wdata, input logic [BW-1:0] rdata,
                                 input logic err, input int acc);
        exp_t e;
        e.id = id; e.wr = wr; e.addr = addr; e.wdata = wdata;
        e.rdata = rdata; e.err = err; e.acc = acc;
        sb.push_back(e);
        m_last = id;
    endfunction

    task automatic wait_done(input int id, input int bound, output int c);
        c = 0;
        while (c < bound) begin
            @(negedge pclk);
            c++;
            if ((id == 0 && bus.done0) || (id == 1 && bus.done1)) return;
        end
        chk("done_never", 32'd0, 32'd1);
    endtask

    task automatic wait_access(input int bound);
        int c;
        c = 0;
        while (c < bound) begin
            @(negedge pclk);
            c++;
            if (bus.psel && bus.penable) return;
        end
        chk("access_never", 32'd0, 32'd1);
    endtask

    // APB slave: pready rises after slv_wait ACCESS cycles; negative slv_wait never answers.
    initial begin
        bus.pready = 1'b0;
        bus.prdata = '0;
        slv_n      = 0;
        forever begin
            @(posedge pclk);
            #1;
            if (bus.psel && bus.penable) begin
                slv_n++;
                bus.pready = (slv_wait >= 0) && (slv_n > slv_wait);
                bus.prdata = bus.pready ? slv_rdata : 8'hEE;
            end else begin
                slv_n      = 0;
                bus.pready = 1'b0;
            end
        end
    end

    always @(negedge pclk) begin
        if (preset) begin
            mon_acc   = 0;
            mon_setup = 0;
        end else begin
            exp_t e;
            chk("done_excl", 32'(bus.done0 & bus.done1), 32'd0);
            if (!(bus.done0 || bus.done1)) chk("err_no_done", 32'(bus.err), 32'd0);
            if (mon_setup) chk("setup_one_cycle", 32'({bus.psel, bus.penable}), 32'd3);
            mon_setup = 0;
            if (bus.psel && !bus.penable) begin
                mon_setup = 1;
                mon_acc   = 0;
                chk("busy_setup", 32'(bus.busy), 32'd1);
                if (sb.size() == 0) begin
                    chk("setup_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("setup_paddr", 32'(bus.paddr), 32'(sb[0].addr));
                    chk("setup_pwrite", 32'(bus.pwrite), 32'(sb[0].wr));
                    if (sb[0].wr) chk("setup_pwdata", 32'(bus.pwdata), 32'(sb[0].wdata));
                end
            end else if (bus.psel && bus.penable) begin
                mon_acc++;
                if (sb.size() > 0) begin
                    chk("access_paddr_hold", 32'(bus.paddr), 32'(sb[0].addr));
                    if (sb[0].wr) chk("access_pwdata_hold", 32'(bus.pwdata), 32'(sb[0].wdata));
                end
            end
            if (bus.done0 || bus.done1) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_id", 32'(bus.done1), 32'(e.id));
                    chk("done_err", 32'(bus.err), 32'(e.err));
                    chk("access_cycles", 32'(mon_acc), 32'(e.acc));
                    if (!e.wr && !e.err) exp_rdata = e.rdata;
                    chk("rdata", 32'(bus.rdata), 32'(exp_rdata));
                    chk("busy_done", 32'(bus.busy), 32'd1);
                end
            end
        end
    end

    initial begin
        preset     = 1'b1;
        bus.req0   = 1'b0; bus.req1   = 1'b0;
        bus.wr0    = 1'b0; bus.wr1    = 1'b0;
        bus.addr0  = '0;   bus.addr1  = '0;
        bus.wdata0 = '0;   bus.wdata1 = '0;
        slv_wait   = 0;
        slv_rdata  = '0;
        exp_rdata  = '0;
        m_last     = 1;
        repeat (3) @(negedge pclk);
        chk("rst_psel", 32'(bus.psel), 32'd0);
        chk("rst_penable", 32'(bus.penable), 32'd0);
        chk("rst_pwrite", 32'(bus.pwrite), 32'd0);
        chk("rst_paddr", 32'(bus.paddr), 32'd0);
        chk("rst_pwdata", 32'(bus.pwdata), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        chk("rst_done", 32'({bus.done0, bus.done1}), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        preset = 1'b0;
        @(negedge pclk);

        // Single write, slave ready immediately
        bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.addr0 = 2'd0; bus.wdata0 = 8'h03;
        slv_wait = 0;
        push(0, 1'b1, 2'd0, 8'h03, 8'h00, 1'b0, 1);
        wait_done(0, 20, cyc);
        chk("wr_latency", 32'(cyc), 32'd3);
        bus.req0 = 1'b0;
        @(negedge pclk);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // Read with three wait states
        bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.addr1 = 2'd2;
        slv_wait = 3; slv_rdata = 8'hAA;
        push(1, 1'b0, 2'd2, 8'h00, 8'hAA, 1'b0, 4);
        wait_done(1, 30, cyc);
        chk("rd_latency", 32'(cyc), 32'd6);
        bus.req1 = 1'b0;
        @(negedge pclk);

        // Both held: grants alternate, back-to-back every 4 cycles
        slv_wait = 0; slv_rdata = 8'h3C;
        bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.addr0 = 2'd1; bus.wdata0 = 8'h55;
        bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.addr1 = 2'd3;
        first = (m_last == 1) ? 0 : 1;
        for (int t = 0; t < 4; t++) begin
            if ((first ^ (t & 1)) == 0) push(0, 1'b1, 2'd1, 8'h55, 8'h00, 1'b0, 1);
            else                         push(1, 1'b0, 2'd3, 8'h00, 8'h3C, 1'b0, 1);
        end
        for (int t = 0; t < 4; t++) begin
            int c;
            c = 0;
            do begin
                @(negedge pclk);
                c++;
            end while (!(bus.done0 || bus.done1) && c < 20);
            chk("contend_id", 32'(bus.done1), 32'(first ^ (t & 1)));
            chk("contend_gap", 32'(c), (t == 0) ? 32'd3 : 32'd4);
            if (t == 3) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
        end
        @(negedge pclk);

        // Timeout: slave never ready
        bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 2'd1;
        slv_wait = -1;
        push(0, 1'b0, 2'd1, 8'h00, 8'h00, 1'b1, TO);
        wait_done(0, 40, cyc);
        chk("to_latency", 32'(cyc), 32'(2 + TO));
        chk("to_rdata_hold", 32'(bus.rdata), 32'h3C);
        bus.req0 = 1'b0;
        @(negedge pclk);

        bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.addr0 = 2'd2; bus.wdata0 = 8'h81;
        slv_wait = 0;
        push(0, 1'b1, 2'd2, 8'h81, 8'h00, 1'b0, 1);
        wait_done(0, 20, cyc);
        chk("post_to_latency", 32'(cyc), 32'd3);
        bus.req0 = 1'b0;
        @(negedge pclk);

        // Late request plus requester-0 inputs changing after grant
        bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.addr0 = 2'd3; bus.wdata0 = 8'h11;
        slv_wait = 2;
        push(0, 1'b1, 2'd3, 8'h11, 8'h00, 1'b0, 3);
        wait_access(20);
        bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.addr1 = 2'd0; slv_rdata = 8'h5A;
        bus.addr0 = 2'd1; bus.wdata0 = 8'hFF;
        push(1, 1'b0, 2'd0, 8'h00, 8'h5A, 1'b0, 1);
        wait_done(0, 20, cyc);
        bus.req0 = 1'b0;
        slv_wait = 0;
        wait_done(1, 20, cyc);
        chk("late_latency", 32'(cyc), 32'd4);
        bus.req1 = 1'b0;
        @(negedge pclk);

        // Reset in the middle of ACCESS takes effect without a clock edge
        bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 2'd0;
        slv_wait = -1;
        push(0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, TO);
        wait_access(20);
        @(negedge pclk);
        #2;
        preset = 1'b1;
        sb.delete();
        m_last    = 1;
        exp_rdata = '0;
        bus.req0  = 1'b0;
        #1;
        chk("arst_psel", 32'(bus.psel), 32'd0);
        chk("arst_penable", 32'(bus.penable), 32'd0);
        chk("arst_done", 32'({bus.done0, bus.done1}), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_rdata", 32'(bus.rdata), 32'd0);
        repeat (2) @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);

        // After reset the last pointer favours requester 0
        slv_wait = 0; slv_rdata = 8'hC3;
        bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.addr0 = 2'd2; bus.wdata0 = 8'h77;
        bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.addr1 = 2'd1;
        push(0, 1'b1, 2'd2, 8'h77, 8'h00, 1'b0, 1);
        push(1, 1'b0, 2'd1, 8'h00, 8'hC3, 1'b0, 1);
        wait_done(0, 20, cyc);
        chk("post_rst_latency", 32'(cyc), 32'd3);
        bus.req0 = 1'b0;
        wait_done(1, 20, cyc);
        chk("post_rst_second", 32'(cyc), 32'd4);
        bus.req1 = 1'b0;
        repeat (3) @(negedge pclk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("final_busy", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
